square_pwm_generator: RTL
=========================

SQUARE_PWM_GENERATOR -- requirements
Module: square_pwm_generator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, output sample width.
- CNT_W, 16, period/duty counter width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  system clock (25 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept.
- cfg_period  in  CNT_W  period P in clk cycles.
- cfg_high  in  CNT_W  high time H in clk cycles.
- cfg_level_hi  in  WIDTH  high output level.
- cfg_level_lo  in  WIDTH  low output level.
- wave_out  out  WIDTH  registered wave sample.
- period_start  out  1  one-cycle pulse on the first cycle of each period.
- active  out  1  high in RUN and STOP states.

Function
REQ-003 Active configuration (P, H, LH, LL) SHALL be registered; the shadow copy SHALL be loaded on cfg_valid && cfg_ready.
REQ-004 Capture SHALL clamp values: P<2 -> P=2; H>P -> H=P; P above 2^CNT_W-1 is not possible by width.
REQ-005 cfg_ready SHALL be 1 when no shadow is pending, and 0 from the cycle after capture until the shadow has been applied.
REQ-006 FSM states SHALL be IDLE, RUN and STOP.
REQ-007 In IDLE: cnt=0, wave_out=LL, active=0, period_start=0; a pending shadow SHALL be applied on the next edge.
REQ-008 IDLE->RUN SHALL occur on the first edge that samples enable=1. In that same cycle, cnt=0, period_start=1 and wave_out=(H>0 ? LH : LL).
REQ-009 In RUN/STOP, on a cycle with count c, wave_out SHALL be LH when c<H and LL otherwise. H=0 gives constant LL; H=P gives constant LH.
REQ-010 cnt SHALL increment each cycle and wrap from P-1 to 0; period_start=1 exactly when cnt=0.
REQ-011 A pending shadow SHALL be applied on the wrap edge, so the new values govern the cycle with cnt=0. pending SHALL clear and cfg_ready SHALL rise in that cycle.
REQ-012 Simultaneous capture and wrap: the shadow captured on that edge SHALL NOT apply at that wrap; it applies at the next wrap.
REQ-013 RUN with enable=0 SHALL move to STOP. The current period SHALL complete, with no truncated high or low phase.
REQ-014 STOP with enable=1 SHALL return to RUN without any discontinuity in cnt or wave_out.
REQ-015 STOP at the wrap edge with enable=0 SHALL move to IDLE; wave_out=LL and active=0 from that cycle.
REQ-016 Period time SHALL be exactly P cycles, with H cycles at LH, for every P in 2..2^CNT_W-1.

Reset
REQ-017 reset_n=0 SHALL immediately, without waiting for a clock edge, force the following values:
- state=IDLE, cnt=0, wave_out=0, period_start=0, active=0, cfg_ready=1.
- Shadow and pending discarded.
- Active config P=2, H=1, LH=all ones, LL=0.
REQ-018 Reset release SHALL be sampled synchronously; the first functional edge follows the release.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (WIDTH=8, CNT_W=16):
- Reset mid-run, then release with enable=1 and no cfg -> wave_out 0 during reset; after release, 255,0,255,0...; period_start every 2 cycles.
- In IDLE, load P=10 H=3 hi=200 lo=10, then enable -> repeating 3x200, 7x10; period_start every 10th cycle; cfg_ready low one cycle then high.
- Running P=10 H=3; at cnt=4 load P=6 H=9 -> old period completes; then constant 200 (H clamped to 6); period_start every 6; cfg_ready stays 0 until the wrap.
- Running P=10 H=3; enable low at cnt=2 -> samples continue to cnt=9, then wave_out=10 and active=0; re-enable at cnt=7 of a fresh stop -> uninterrupted run.
- cfg_period=1 cfg_high=0 -> P=2, constant lo level; cfg_period=0 -> P=2.
- Assert reset_n low while a shadow is pending mid-run -> outputs reset asynchronously; after release, P=2/H=1 defaults run; the old shadow is never applied.

Source files
------------

// File: rtl/square_pwm_generator.sv
// Square-wave / PWM sample generator with a handshaked shadow configuration
// that is applied only on period boundaries, so waveform phases are never cut short.
module square_pwm_generator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [WIDTH-1:0] cfg_level_hi,
   input  logic [WIDTH-1:0] cfg_level_lo,
   output logic [WIDTH-1:0] wave_out,
   output logic             period_start,
   output logic             active
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t           state_r, state_n_s;
   logic [CNT_W-1:0] cnt_r, cnt_n_s;
   logic [CNT_W-1:0] per_r, high_r, sh_per_r, sh_high_r;
   logic [WIDTH-1:0] lvl_hi_r, lvl_lo_r, sh_lvl_hi_r, sh_lvl_lo_r;
   logic [CNT_W-1:0] per_n_s, high_n_s, clamp_per_s;
   logic [WIDTH-1:0] lvl_hi_n_s, lvl_lo_n_s, wave_n_s;
   logic             pending_s, capture_s, wrap_s, apply_s, pstart_n_s, ready_n_s;

   function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
      return (p < CNT_W'(2)) ? CNT_W'(2) : p;
   endfunction

   function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] h,
                                                   input logic [CNT_W-1:0] p);
      return (h > p) ? p : h;
   endfunction

   // A pending shadow is simply the absence of cfg_ready.
   assign pending_s   = ~cfg_ready;
   assign capture_s   = cfg_valid & cfg_ready;
   assign wrap_s      = (cnt_r == (per_r - CNT_W'(1)));
   assign clamp_per_s = clamp_period(cfg_period);

   // Next-state, next-count and config-apply decision.
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      apply_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_n_s = {CNT_W{1'b0}};
            apply_s = pending_s;
            if (enable) state_n_s = ST_RUN;
            else        state_n_s = ST_IDLE;
         end
         ST_RUN: begin
            cnt_n_s = wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            apply_s = pending_s & wrap_s;
            if (enable) state_n_s = ST_RUN;
            else        state_n_s = ST_STOP;
         end
         ST_STOP: begin
            cnt_n_s = wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            apply_s = pending_s & wrap_s;
            if (enable)      state_n_s = ST_RUN;
            else if (wrap_s) state_n_s = ST_IDLE;
            else             state_n_s = ST_STOP;
         end
         default: begin
            state_n_s = ST_IDLE;
            cnt_n_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output samples are computed from the config that governs the upcoming cycle.
   always_comb begin
      per_n_s    = apply_s ? sh_per_r    : per_r;
      high_n_s   = apply_s ? sh_high_r   : high_r;
      lvl_hi_n_s = apply_s ? sh_lvl_hi_r : lvl_hi_r;
      lvl_lo_n_s = apply_s ? sh_lvl_lo_r : lvl_lo_r;
      if (state_n_s == ST_IDLE) begin
         wave_n_s   = lvl_lo_n_s;
         pstart_n_s = 1'b0;
      end else begin
         wave_n_s   = (cnt_n_s < high_n_s) ? lvl_hi_n_s : lvl_lo_n_s;
         pstart_n_s = (cnt_n_s == {CNT_W{1'b0}});
      end
      if (capture_s)    ready_n_s = 1'b0;
      else if (apply_s) ready_n_s = 1'b1;
      else              ready_n_s = cfg_ready;
   end

   // State, counter, active config and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         per_r        <= CNT_W'(2);
         high_r       <= CNT_W'(1);
         lvl_hi_r     <= {WIDTH{1'b1}};
         lvl_lo_r     <= {WIDTH{1'b0}};
         wave_out     <= {WIDTH{1'b0}};
         period_start <= 1'b0;
         active       <= 1'b0;
         cfg_ready    <= 1'b1;
      end else begin
         state_r      <= state_n_s;
         cnt_r        <= cnt_n_s;
         per_r        <= per_n_s;
         high_r       <= high_n_s;
         lvl_hi_r     <= lvl_hi_n_s;
         lvl_lo_r     <= lvl_lo_n_s;
         wave_out     <= wave_n_s;
         period_start <= pstart_n_s;
         active       <= (state_n_s != ST_IDLE);
         cfg_ready    <= ready_n_s;
      end
   end

   // Shadow capture, clamped on the way in.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_per_r    <= CNT_W'(2);
         sh_high_r   <= CNT_W'(1);
         sh_lvl_hi_r <= {WIDTH{1'b1}};
         sh_lvl_lo_r <= {WIDTH{1'b0}};
      end else if (capture_s) begin
         sh_per_r    <= clamp_per_s;
         sh_high_r   <= clamp_high(cfg_high, clamp_per_s);
         sh_lvl_hi_r <= cfg_level_hi;
         sh_lvl_lo_r <= cfg_level_lo;
      end else begin
         sh_per_r    <= sh_per_r;
         sh_high_r   <= sh_high_r;
         sh_lvl_hi_r <= sh_lvl_hi_r;
         sh_lvl_lo_r <= sh_lvl_lo_r;
      end
   end

endmodule
